iz_neuron_scheduler: RTL

Time-multiplexing controller that shares one Izhikevich update engine across `N_NEURONS` virtual neurons. It holds each neuron's `v`/`u` state and 8-bit stimulus, and on every timestep tick it sweeps all neurons in index order through the engine over a req/ack handshake. It writes the results back and queues spike events in a small FIFO for the output side. It sits between the parameter loader (`params_ready`) and a shared update datapath, replacing one-engine-per-neuron instantiation.

---
 rtl/iz_sched_pkg.sv | 7 +
 rtl/iz_spike_fifo.sv | 35 +++
 rtl/iz_neuron_scheduler.sv | 108 ++++++++++
 3 files changed

// File: rtl/iz_sched_pkg.sv
// iz_sched_pkg: shared types and reset defaults for the Izhikevich neuron scheduler
package iz_sched_pkg;
  typedef enum logic [1:0] {SCHED_IDLE, SCHED_REQ, SCHED_DONE} sched_state_t;
  localparam logic [15:0] V_INIT_DEF = 16'hBF00;
  localparam logic [15:0] U_INIT_DEF = 16'hF300;
  typedef logic signed [15:0] q8_8_t;
endpackage

// File: rtl/iz_spike_fifo.sv
// iz_spike_fifo: synchronous FIFO; push/pop in, din/dout data, full/empty flags; a push on full succeeds only alongside a pop
module iz_spike_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign empty = wr == rd;
  assign full = wr == {~rd[AW], rd[AW-1:0]};
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + (AW+1)'(1);
      if (do_pop) rd <= rd + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/iz_neuron_scheduler.sv
// iz_neuron_scheduler: sweeps N virtual neurons through one shared Izhikevich engine per tick
// Ports: control (enable, params_ready, tick), stimulus writes (stim_*), engine handshake (upd_*),
// spike event stream (evt_*), status (busy, sweep_done, overrun, evt_overflow, clear_flags).
module iz_neuron_scheduler
  import iz_sched_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IDX_W = 2,
  parameter int STATE_W = 16,
  parameter logic [STATE_W-1:0] V_INIT = STATE_W'(V_INIT_DEF),
  parameter logic [STATE_W-1:0] U_INIT = STATE_W'(U_INIT_DEF),
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               params_ready,
  input  logic               tick,
  input  logic               stim_we,
  input  logic [IDX_W-1:0]   stim_idx,
  input  logic [7:0]         stim_data,
  output logic               upd_req,
  output logic [IDX_W-1:0]   upd_idx,
  output logic [STATE_W-1:0] upd_v,
  output logic [STATE_W-1:0] upd_u,
  output logic [7:0]         upd_i,
  input  logic               upd_ack,
  input  logic [STATE_W-1:0] upd_v_next,
  input  logic [STATE_W-1:0] upd_u_next,
  input  logic               upd_spike,
  output logic               evt_valid,
  output logic [IDX_W-1:0]   evt_idx,
  input  logic               evt_ready,
  output logic               busy,
  output logic               sweep_done,
  output logic               overrun,
  output logic               evt_overflow,
  input  logic               clear_flags
);
  sched_state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [STATE_W-1:0] v [N_NEURONS];
  logic [STATE_W-1:0] u [N_NEURONS];
  logic [7:0] stim [N_NEURONS];
  logic ack, last, push, pop, full, empty;
  assign upd_req = state == SCHED_REQ;
  assign busy = upd_req;
  assign sweep_done = state == SCHED_DONE;
  assign upd_idx = idx;
  assign upd_v = v[idx];
  assign upd_u = u[idx];
  assign upd_i = stim[idx];
  assign ack = enable & upd_req & upd_ack;
  assign last = idx == IDX_W'(N_NEURONS - 1);
  assign push = ack & upd_spike;
  assign pop = enable & evt_valid & evt_ready;
  assign evt_valid = !empty;
  // idx wraps to 0 after the last neuron since N_NEURONS is a power of two
  always_comb begin
    state_n = state;
    idx_n = idx;
    if (enable) begin
      if (state == SCHED_IDLE && tick && params_ready) begin
        state_n = SCHED_REQ;
        idx_n = '0;
      end else if (ack) begin
        state_n = last ? SCHED_DONE : SCHED_REQ;
        idx_n = idx + IDX_W'(1);
      end else if (state == SCHED_DONE) begin
        state_n = SCHED_IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCHED_IDLE;
      idx <= '0;
      overrun <= 1'b0;
      evt_overflow <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i] <= V_INIT;
        u[i] <= U_INIT;
        stim[i] <= '0;
      end
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (ack) begin
        v[idx] <= upd_v_next;
        u[idx] <= upd_u_next;
      end
      if (stim_we) stim[stim_idx] <= stim_data;
      overrun <= !clear_flags && (overrun || (enable && tick && state != SCHED_IDLE));
      // a pop in the same cycle frees the slot, so only a push on full without pop is a drop
      evt_overflow <= !clear_flags && (evt_overflow || (push && full && !pop));
    end
  end
  iz_spike_fifo #(.W(IDX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (idx),
    .dout  (evt_idx),
    .full  (full),
    .empty (empty)
  );
endmodule
